// File: rtl/eth_rx_block_sync.sv
// eth_rx_block_sync: 64b/66b block lock acquisition and tracking, gearbox
// bit-slip requests, and self-synchronising x^58+x^39+1 descrambling of the
// 32-bit payload stream. Output valids are gated by block lock.
module eth_rx_block_sync #(
    parameter int DATAPATH_WIDTH = 32,
    parameter int LOCK_COUNT     = 64,
    parameter int BAD_LIMIT      = 16,
    parameter int SLIP_WAIT      = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [DATAPATH_WIDTH-1:0] i_data,
    input  logic                      i_data_valid,
    input  logic [1:0]                i_header,
    input  logic                      i_header_valid,
    output logic [DATAPATH_WIDTH-1:0] o_data,
    output logic                      o_data_valid,
    output logic [1:0]                o_header,
    output logic                      o_header_valid,
    output logic                      o_block_lock,
    output logic                      o_gt_slip,
    output logic [7:0]                o_slip_count
);

    if (DATAPATH_WIDTH != 32) begin : g_width_check
        $error("eth_rx_block_sync: only DATAPATH_WIDTH=32 is supported");
    end

    localparam int HIST_W = 58;
    localparam int CNT_W  = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W  = $clog2(BAD_LIMIT + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LOCK_COUNT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(BAD_LIMIT - 1);
    localparam logic [BAD_W-1:0]  BAD_ONE   = BAD_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_LOCKED,
        ST_SLIP,
        ST_SLIP_WAIT
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    good_cnt;
    logic [CNT_W-1:0]    win_cnt;
    logic [BAD_W-1:0]    bad_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                block_lock;
    logic                gt_slip;
    logic [7:0]          slip_count;

    logic [HIST_W-1:0]         hist_p0;
    logic [DATAPATH_WIDTH-1:0] data_p1;
    logic [1:0]                hdr_p1;
    logic                      vld_p1;
    logic                      hdr_vld_p1;

    logic hdr_evt;
    logic hdr_good;
    logic lock_rise;
    logic lock_fall;
    logic lock_nxt;

    // Slip counter saturates rather than wrapping so a flapping link stays visible.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Bit k (wire order) = s[k] ^ s[k-39] ^ s[k-58]; earlier bits come from the
    // history, laid out so hist[HIST_W-1] is the most recent prior scrambled bit.
    function automatic logic [DATAPATH_WIDTH-1:0] descramble(
        input logic [DATAPATH_WIDTH-1:0] din,
        input logic [HIST_W-1:0]         hist
    );
        logic [DATAPATH_WIDTH+HIST_W-1:0] ext;
        logic [DATAPATH_WIDTH-1:0]        dout;
        ext = {din, hist};
        for (int k = 0; k < DATAPATH_WIDTH; k++) begin
            dout[k] = ext[k + HIST_W] ^ ext[k + HIST_W - 39] ^ ext[k];
        end
        return dout;
    endfunction

    assign hdr_evt   = i_data_valid & i_header_valid;
    assign hdr_good  = (i_header == 2'b01) | (i_header == 2'b10);
    // Lock changes are known before the edge so the output valids can follow
    // o_block_lock on the very same edge.
    assign lock_rise = (state == ST_UNLOCKED) & hdr_evt & hdr_good & (good_cnt == CNT_LAST);
    assign lock_fall = (state == ST_LOCKED) & hdr_evt & ~hdr_good & (bad_cnt == BAD_LAST);
    assign lock_nxt  = (block_lock | lock_rise) & ~lock_fall;

    // Lock FSM: acquire on consecutive good headers, monitor windows, slip and settle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_UNLOCKED;
            good_cnt   <= '0;
            win_cnt    <= '0;
            bad_cnt    <= '0;
            wait_cnt   <= '0;
            block_lock <= 1'b0;
            gt_slip    <= 1'b0;
            slip_count <= 8'd0;
        end else begin
            gt_slip    <= 1'b0;
            block_lock <= lock_nxt;
            case (state)
                ST_UNLOCKED: begin
                    if (hdr_evt) begin
                        if (!hdr_good) begin
                            state      <= ST_SLIP;
                            gt_slip    <= 1'b1;
                            slip_count <= sat_inc8(slip_count);
                            good_cnt   <= '0;
                        end else if (lock_rise) begin
                            state    <= ST_LOCKED;
                            good_cnt <= '0;
                            win_cnt  <= '0;
                            bad_cnt  <= '0;
                        end else begin
                            good_cnt <= good_cnt + CNT_ONE;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (hdr_evt) begin
                        if (lock_fall) begin
                            state      <= ST_SLIP;
                            gt_slip    <= 1'b1;
                            slip_count <= sat_inc8(slip_count);
                            win_cnt    <= '0;
                            bad_cnt    <= '0;
                        end else if (win_cnt == CNT_LAST) begin
                            win_cnt <= '0;
                            bad_cnt <= '0;
                        end else begin
                            win_cnt <= win_cnt + CNT_ONE;
                            if (!hdr_good) begin
                                bad_cnt <= bad_cnt + BAD_ONE;
                            end
                        end
                    end
                end
                ST_SLIP: begin
                    state    <= ST_SLIP_WAIT;
                    wait_cnt <= '0;
                end
                ST_SLIP_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state    <= ST_UNLOCKED;
                        good_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_ONE;
                    end
                end
                default: begin
                    state <= ST_UNLOCKED;
                end
            endcase
        end
    end

    // Datapath: descrambler history advances on valid beats only; outputs are
    // registered once with valids gated by the post-edge lock state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hist_p0    <= '0;
            data_p1    <= '0;
            hdr_p1     <= 2'b00;
            vld_p1     <= 1'b0;
            hdr_vld_p1 <= 1'b0;
        end else begin
            data_p1    <= descramble(i_data, hist_p0);
            hdr_p1     <= i_header;
            vld_p1     <= i_data_valid & lock_nxt;
            hdr_vld_p1 <= i_data_valid & i_header_valid & lock_nxt;
            if (i_data_valid) begin
                hist_p0 <= {i_data, hist_p0[HIST_W-1:DATAPATH_WIDTH]};
            end
        end
    end

    assign o_data         = data_p1;
    assign o_header       = hdr_p1;
    assign o_data_valid   = vld_p1;
    assign o_header_valid = hdr_vld_p1;
    assign o_block_lock   = block_lock;
    assign o_gt_slip      = gt_slip;
    assign o_slip_count   = slip_count;

endmodule
